// File: rtl/cache_pkg.sv
// Shared definitions for the blocking write-back cache controller.
// Holds the address field widths, the line geometry, the RV32I load/store
// width codes and the controller state encoding.
package cache_pkg;

  localparam int ADDR_BITS       = 32;
  localparam int TAG_BITS        = 23;
  localparam int SET_INDEX_WIDTH = 5;
  localparam int ELEMENT_WORDS   = 4;

  // RV32I funct3 width/sign codes carried on *_u_b_h_w
  typedef enum logic [2:0] {
    W_B  = 3'b000,
    W_H  = 3'b001,
    W_W  = 3'b010,
    W_BU = 3'b100,
    W_HU = 3'b101
  } width_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BACK = 2'd1,
    S_FILL = 2'd2,
    S_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/cache_controller.sv
// Blocking miss handler between a CPU port, a tag/data cache array and a
// word-wide memory port.
//
// state  | meaning
// S_IDLE | pass CPU request to the cache; a hit completes this cycle
// S_BACK | write the dirty victim line to memory, one word per ack
// S_FILL | read the requested line from memory into the cache
// S_WAIT | one settle cycle before the request is retried as a hit
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_*                            CPU request and load data, stall
//   cache_*                          cache array strobes, address, data, lookup result
//   mem_*                            memory request, address, data, per-word ack
module cache_controller #(
  parameter int ADDR_BITS     = cache_pkg::ADDR_BITS,
  parameter int TAG_BITS      = cache_pkg::TAG_BITS,
  parameter int ELEMENT_WORDS = cache_pkg::ELEMENT_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic                 req_load,
  input  logic                 req_store,
  input  logic [2:0]           req_u_b_h_w,
  input  logic [31:0]          req_din,
  output logic [31:0]          req_dout,
  output logic                 stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_store,
  output logic                 cache_replace,
  output logic                 cache_invalid,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic [31:0]          cache_dout,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i,
  input  logic                 mem_ack_i
);
  import cache_pkg::*;

  localparam int WORD_W = $clog2(ELEMENT_WORDS);
  localparam int IDX_W  = ADDR_BITS - TAG_BITS - WORD_W - 2;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(ELEMENT_WORDS - 1);

  state_t                r_state;
  logic [WORD_W-1:0]     r_cnt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [TAG_BITS-1:0]   r_victim_tag;

  logic [TAG_BITS-1:0]   w_req_tag;
  logic [IDX_W-1:0]      w_index;
  logic [ADDR_BITS-1:0]  w_fill_addr;
  logic [ADDR_BITS-1:0]  w_back_addr;
  logic                  w_miss;

  assign w_req_tag   = r_addr[ADDR_BITS-1 -: TAG_BITS];
  assign w_index     = r_addr[WORD_W+2 +: IDX_W];
  assign w_fill_addr = {w_req_tag, w_index, r_cnt, 2'b00};
  assign w_back_addr = {r_victim_tag, w_index, r_cnt, 2'b00};
  assign w_miss      = (req_load | req_store) & ~cache_hit;

  // Outputs are decoded from the registered state so a hit can finish in the
  // same cycle; reset forces every strobe low even before the state settles.
  always_comb begin
    req_dout      = '0;
    stall         = 1'b0;
    cache_addr    = '0;
    cache_load    = 1'b0;
    cache_store   = 1'b0;
    cache_replace = 1'b0;
    cache_invalid = 1'b0;
    cache_u_b_h_w = W_W;
    cache_din     = '0;
    mem_cs_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          cache_addr    = req_addr;
          // load and store together behave as a store
          cache_load    = req_load & ~req_store;
          cache_store   = req_store & cache_hit;
          cache_din     = req_din;
          cache_u_b_h_w = req_u_b_h_w;
          req_dout      = cache_dout;
          stall         = w_miss;
        end
        S_BACK: begin
          // cache_addr carries the requested tag so the array misses and
          // drives the victim way's word onto cache_dout
          cache_addr = w_fill_addr;
          mem_cs_o   = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = w_back_addr;
          mem_data_o = cache_dout;
          stall      = 1'b1;
        end
        S_FILL: begin
          cache_addr    = w_fill_addr;
          cache_replace = mem_ack_i;
          cache_din     = mem_data_i;
          mem_cs_o      = 1'b1;
          mem_addr_o    = w_fill_addr;
          stall         = 1'b1;
        end
        S_WAIT: stall = 1'b1;
        default: stall = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_victim_tag <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_addr       <= req_addr;
            r_victim_tag <= cache_tag;
            r_cnt        <= '0;
            r_state      <= (cache_valid & cache_dirty) ? S_BACK : S_FILL;
          end
        end
        S_BACK: begin
          if (mem_ack_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_WORD) r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_WORD) r_state <= S_WAIT;
          end
        end
        S_WAIT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
